wash_seq_ctrl: RTL and testbench
================================

# wash_seq_ctrl

Program sequencer for the washing-machine controller. It latches a selected wash program and runs it phase by phase (fill, wash, drain, rinse, spin), counting down the phase time and the total time. It drives the phase lights and phase code, and supports start/pause/resume from the single start button. It sits directly above the display and lights logic and is clocked by the system clock `ts`.

## Interface
- `TICK_DIV`, default 1: `ts` cycles per time unit. Must be ≥1.
- `T_FILL`, default 2: fill duration, in time units.
- `T_WASH`, default 9: wash duration.
- `T_DRAIN`, default 2: drain duration.
- `T_RINSE`, default 6: rinse duration.
- `T_SPIN`, default 5: spin duration.
- Constraint on the durations: each is 1..31, and every program total is ≤63.

Ports:
- `ts` in 1: the single clock; all logic is on its rising edge.
- `p` in 1: power, acting as the reset; asynchronous, active-low. `p`=0 resets the block.
- `mod` in 1: program-load strobe, level-sampled.
- `mod1` in 3: program select; valid values 0..4.
- `s` in 1: start/pause button, rising-edge detected.
- `Tt` out 6: total time units remaining.
- `Tm` out 5: time units remaining in the current phase.
- `li` out 1: water-inlet light.
- `lw` out 1: wash light.
- `lo` out 1: water-outlet light.
- `lr` out 1: rinse light.
- `ld` out 1: spin (dry) light.
- `tp` out 4: current phase code.
- `run` out 1: a program is actively counting.
- `done` out 1: the program has completed.

## Operation
- Phase codes (`tp`): IDLE=0, FILL=1, WASH=2, DRAIN=3, RFILL=4, RINSE=5, RDRAIN=6, SPIN=7, DONE=8. Codes 9..15 are never produced.
- Programs and their phase sequences:
  - 0: 1,2,3,4,5,6,7; total 28 with defaults.
  - 1: 1,2,3; total 13.
  - 2: 1,2,3,4,5,6; total 23.
  - 3: 4,5,6,7; total 15.
  - 4: 7; total 5.
- Phase durations: FILL and RFILL use T_FILL; DRAIN and RDRAIN use T_DRAIN.
- Lights are one-hot while running:
  - `li` in FILL/RFILL.
  - `lw` in WASH.
  - `lo` in DRAIN/RDRAIN.
  - `lr` in RINSE.
  - `ld` in SPIN.
  - All lights are 0 in IDLE, DONE and while paused.
- Load: when `mod`=1 in IDLE or DONE and `mod1`≤4, the block latches the program and sets Tt=program total, Tm=0, tp=IDLE, done=0.
  - `mod1`≥5 is ignored; all state is unchanged.
  - `mod` is ignored while running or paused.
- Start/pause on a rising edge of `s`:
  - IDLE with Tt≠0 → enter the first phase, Tm=its duration, run=1. IDLE with Tt=0 is ignored.
  - Running → paused: run=0, prescaler frozen, Tt, Tm and tp held.
  - Paused → running, with the prescaler continuing from its held count.
  - DONE → IDLE with Tt reloaded to the latched program total.
- Tick: while running, one tick occurs every TICK_DIV cycles. On each tick:
  - Tt decrements by 1.
  - If Tm>1, Tm decrements by 1.
  - Otherwise the block advances to the next phase of the program and loads Tm with that phase's duration.
  - After the last phase: tp=DONE, Tm=0, Tt=0, run=0, done=1.
- Counters never wrap. Tt and Tm never go below 0. Tt equals the sum of the remaining Tm values at all times.

## Timing
- Reset (`p`=0), asynchronous: Tt=0, Tm=0, all lights 0, tp=0, run=0, done=0, no program latched, prescaler=0, and the `s` edge register=0.
- Edge detect: s_q is registered. An edge is `s`&~s_q, acted on at the same rising edge of `ts`, so outputs change one edge after `s` is sampled high.
- Start latency: the first phase is visible right after the start edge. The first tick occurs TICK_DIV cycles later.
- A program of total N completes N·TICK_DIV cycles after the start edge, excluding any paused cycles.
- Simultaneous `mod`=1 and an `s` edge in IDLE or DONE: the load wins and the edge is discarded.
- A tick coinciding with a pause edge: the pause wins and the tick is not applied.
- `p` deasserted mid-run: the block returns to the reset state immediately, with no drain phase.

## Structure
- Package `wash_pkg` holds:
  - the phase-code localparams;
  - the program-select codes;
  - a function `next_phase(prog, phase)` that returns the successor phase, with DONE after the last phase;
  - a function `first_phase(prog)`.
- Program totals are computed from the parameters inside the block.
- Sub-module `wash_tick_div`: a TICK_DIV prescaler with enable and clear, producing a one-cycle `tick`.

## Test plan
- Reset and no-load start:
  - Stimulus: `p`=0, then `p`=1, then an `s` edge.
  - Required: all outputs stay 0 and tp=0.
- Program 0, TICK_DIV=1:
  - After load, Tt=28. The start edge gives tp=1, li=1, Tm=2.
  - tp then steps 2,3,4,5,6,7 at cycles 2,11,13,15,21,23.
  - At cycle 28: tp=8, done=1, Tt=0.
- Program 4:
  - After load, Tt=5. The start edge gives tp=7, ld=1, Tm=5.
  - done=1 exactly 5 cycles after the start edge.
- Pause on program 1:
  - Pause 4 cycles after start: Tt=9, Tm=7, tp=2, lw=0, run=0, all held for 20 cycles.
  - After resume, done=1 nine cycles later.
- Ignored loads:
  - `mod1`=6 with `mod`=1 in IDLE leaves Tt unchanged.
  - `mod`=1 with `mod1`=4 while running on program 0 leaves the sequence unchanged.
  - In DONE, `mod`=1 together with an `s` edge loads the program and stays in IDLE.
- Power-off mid-run:
  - `p`=0 during RINSE with TICK_DIV=3: all outputs go 0 asynchronously, before the next `ts` edge.
  - After `p`=1, an `s` edge is ignored until a new load.

Source files
------------

// File: rtl/wash_pkg.sv
// wash_pkg: shared definitions for the washing-machine program sequencer.
//   - phase codes shown on the phase display (tp)
//   - program-select codes accepted on mod1
//   - sequencer mode enum (idle / running / paused / finished)
//   - next_phase(): successor phase within a program, DONE after the last one
//   - first_phase(): entry phase of a program
package wash_pkg;

    localparam logic [3:0] PH_IDLE   = 4'd0;
    localparam logic [3:0] PH_FILL   = 4'd1;
    localparam logic [3:0] PH_WASH   = 4'd2;
    localparam logic [3:0] PH_DRAIN  = 4'd3;
    localparam logic [3:0] PH_RFILL  = 4'd4;
    localparam logic [3:0] PH_RINSE  = 4'd5;
    localparam logic [3:0] PH_RDRAIN = 4'd6;
    localparam logic [3:0] PH_SPIN   = 4'd7;
    localparam logic [3:0] PH_DONE   = 4'd8;

    localparam logic [2:0] PROG_FULL       = 3'd0; // fill..spin
    localparam logic [2:0] PROG_QUICK      = 3'd1; // fill, wash, drain
    localparam logic [2:0] PROG_NO_SPIN    = 3'd2; // full cycle without spin
    localparam logic [2:0] PROG_RINSE_SPIN = 3'd3; // rinse cycle + spin
    localparam logic [2:0] PROG_SPIN_ONLY  = 3'd4; // spin alone
    localparam logic [2:0] PROG_LAST       = PROG_SPIN_ONLY;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } seq_state_t;

    function automatic logic [3:0] next_phase(input logic [2:0] prog, input logic [3:0] phase);
        logic [3:0] nxt;
        nxt = PH_DONE;
        case (phase)
            PH_FILL:   nxt = PH_WASH;
            PH_WASH:   nxt = PH_DRAIN;
            PH_DRAIN:  nxt = (prog == PROG_QUICK) ? PH_DONE : PH_RFILL;
            PH_RFILL:  nxt = PH_RINSE;
            PH_RINSE:  nxt = PH_RDRAIN;
            PH_RDRAIN: nxt = (prog == PROG_NO_SPIN) ? PH_DONE : PH_SPIN;
            default:   nxt = PH_DONE;
        endcase
        return nxt;
    endfunction

    function automatic logic [3:0] first_phase(input logic [2:0] prog);
        logic [3:0] ph;
        case (prog)
            PROG_RINSE_SPIN: ph = PH_RFILL;
            PROG_SPIN_ONLY:  ph = PH_SPIN;
            default:         ph = PH_FILL;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/wash_tick_div.sv
// wash_tick_div: time-unit prescaler. Counts enabled cycles and emits a
// one-cycle tick on every DIV-th one. While en is low the count is frozen,
// so a paused program resumes exactly where it left off.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   en    : count this cycle
//   clr   : force the count back to zero (has priority over en)
//   tick  : high during the enabled cycle that completes a time unit
module wash_tick_div #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;

    assign tick = en && (cnt_reg == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= tick ? '0 : cnt_reg + CW'(1);
        end
    end
endmodule

// File: rtl/wash_seq_ctrl.sv
// wash_seq_ctrl: washing-machine program sequencer.
// Latches a program, then steps through its phases counting down the phase
// time (Tm) and total time (Tt). The start button toggles run/pause.
//   ts        : clock
//   p         : power, asynchronous active-low reset
//   mod, mod1 : program-load strobe and program select (0..4)
//   s         : start/pause button, rising-edge detected
//   Tt, Tm    : total / phase time units remaining
//   li..ld    : one-hot phase lights, only while running
//   tp        : phase code
//   run, done : counting / completed
module wash_seq_ctrl
    import wash_pkg::*;
#(
    parameter int TICK_DIV = 1,
    parameter int T_FILL   = 2,
    parameter int T_WASH   = 9,
    parameter int T_DRAIN  = 2,
    parameter int T_RINSE  = 6,
    parameter int T_SPIN   = 5
) (
    input  logic       ts,
    input  logic       p,
    input  logic       mod,
    input  logic [2:0] mod1,
    input  logic       s,
    output logic [5:0] Tt,
    output logic [4:0] Tm,
    output logic       li,
    output logic       lw,
    output logic       lo,
    output logic       lr,
    output logic       ld,
    output logic [3:0] tp,
    output logic       run,
    output logic       done
);
    localparam logic [5:0] TOT_FULL  = 6'(2*T_FILL + T_WASH + 2*T_DRAIN + T_RINSE + T_SPIN);
    localparam logic [5:0] TOT_QUICK = 6'(T_FILL + T_WASH + T_DRAIN);
    localparam logic [5:0] TOT_NOSPN = 6'(2*T_FILL + T_WASH + 2*T_DRAIN + T_RINSE);
    localparam logic [5:0] TOT_RINSP = 6'(T_FILL + T_RINSE + T_DRAIN + T_SPIN);
    localparam logic [5:0] TOT_SPIN  = 6'(T_SPIN);

    function automatic logic [5:0] prog_total(input logic [2:0] pr);
        logic [5:0] t;
        case (pr)
            PROG_FULL:       t = TOT_FULL;
            PROG_QUICK:      t = TOT_QUICK;
            PROG_NO_SPIN:    t = TOT_NOSPN;
            PROG_RINSE_SPIN: t = TOT_RINSP;
            PROG_SPIN_ONLY:  t = TOT_SPIN;
            default:         t = 6'd0;
        endcase
        return t;
    endfunction

    function automatic logic [4:0] phase_dur(input logic [3:0] ph);
        logic [4:0] d;
        case (ph)
            PH_FILL, PH_RFILL:   d = 5'(T_FILL);
            PH_WASH:             d = 5'(T_WASH);
            PH_DRAIN, PH_RDRAIN: d = 5'(T_DRAIN);
            PH_RINSE:            d = 5'(T_RINSE);
            PH_SPIN:             d = 5'(T_SPIN);
            default:             d = 5'd0;
        endcase
        return d;
    endfunction

    seq_state_t state_reg, state_next;
    logic [3:0] phase_reg, phase_next;
    logic [5:0] tt_reg, tt_next;
    logic [4:0] tm_reg, tm_next;
    logic [2:0] prog_reg, prog_next;
    logic       s_q_reg;

    logic       s_edge;
    logic       load_ok;
    logic       tick_en;
    logic       tick_clr;
    logic       tick;
    logic [3:0] nxt_ph;

    assign s_edge  = s & ~s_q_reg;
    assign load_ok = mod && (mod1 <= PROG_LAST) &&
                     (state_reg == ST_IDLE || state_reg == ST_DONE);
    // A pause edge freezes the prescaler in the same cycle, so a coinciding
    // tick is neither applied nor lost from the count.
    assign tick_en  = (state_reg == ST_RUN) && !s_edge;
    assign tick_clr = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign nxt_ph   = next_phase(prog_reg, phase_reg);

    wash_tick_div #(.DIV(TICK_DIV)) u_tick_div (
        .clk   (ts),
        .rst_n (p),
        .en    (tick_en),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_ff @(posedge ts or negedge p) begin
        if (!p) begin
            state_reg <= ST_IDLE;
            phase_reg <= PH_IDLE;
            tt_reg    <= '0;
            tm_reg    <= '0;
            prog_reg  <= '0;
            s_q_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            tt_reg    <= tt_next;
            tm_reg    <= tm_next;
            prog_reg  <= prog_next;
            s_q_reg   <= s;
        end
    end

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        tt_next    = tt_reg;
        tm_next    = tm_reg;
        prog_next  = prog_reg;
        if (load_ok) begin
            // A load beats a simultaneous button edge.
            prog_next  = mod1;
            tt_next    = prog_total(mod1);
            tm_next    = 5'd0;
            phase_next = PH_IDLE;
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // Tt is zero until a program is latched, so this also
                    // blocks starts after power-up.
                    if (s_edge && tt_reg != 6'd0) begin
                        phase_next = first_phase(prog_reg);
                        tm_next    = phase_dur(first_phase(prog_reg));
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (s_edge) begin
                        state_next = ST_PAUSE;
                    end else if (tick) begin
                        if (tt_reg != 6'd0) begin
                            tt_next = tt_reg - 6'd1;
                        end
                        if (tm_reg > 5'd1) begin
                            tm_next = tm_reg - 5'd1;
                        end else if (nxt_ph == PH_DONE) begin
                            phase_next = PH_DONE;
                            tm_next    = 5'd0;
                            tt_next    = 6'd0;
                            state_next = ST_DONE;
                        end else begin
                            phase_next = nxt_ph;
                            tm_next    = phase_dur(nxt_ph);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (s_edge) begin
                        state_next = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (s_edge) begin
                        phase_next = PH_IDLE;
                        tt_next    = prog_total(prog_reg);
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign Tt   = tt_reg;
    assign Tm   = tm_reg;
    assign tp   = phase_reg;
    assign run  = (state_reg == ST_RUN);
    assign done = (state_reg == ST_DONE);
    assign li   = run && (phase_reg == PH_FILL || phase_reg == PH_RFILL);
    assign lw   = run && (phase_reg == PH_WASH);
    assign lo   = run && (phase_reg == PH_DRAIN || phase_reg == PH_RDRAIN);
    assign lr   = run && (phase_reg == PH_RINSE);
    assign ld   = run && (phase_reg == PH_SPIN);
endmodule

// File: tb/tb_wash_seq_ctrl.sv
// Testbench for wash_seq_ctrl: two instances (TICK_DIV=1 and 3) share the
// same stimulus. A phase-list reference model predicts the outputs of both
// after each clock edge; expectations go into a scoreboard queue and a
// separate monitor pops and compares them after every rising edge.
module tb_wash_seq_ctrl;
    localparam int TF = 2, TW = 9, TD = 2, TR = 6, TS = 5;

    logic       ts = 1'b0;
    logic       p = 1'b0;
    logic       mod = 1'b0;
    logic [2:0] mod1 = 3'd0;
    logic       s = 1'b0;

    logic [5:0] tt_a, tt_b;
    logic [4:0] tm_a, tm_b;
    logic [3:0] tp_a, tp_b;
    logic li_a, lw_a, lo_a, lr_a, ld_a, run_a, done_a;
    logic li_b, lw_b, lo_b, lr_b, ld_b, run_b, done_b;

    wash_seq_ctrl #(.TICK_DIV(1), .T_FILL(TF), .T_WASH(TW), .T_DRAIN(TD),
                    .T_RINSE(TR), .T_SPIN(TS)) u_div1 (
        .ts(ts), .p(p), .mod(mod), .mod1(mod1), .s(s),
        .Tt(tt_a), .Tm(tm_a), .li(li_a), .lw(lw_a), .lo(lo_a), .lr(lr_a),
        .ld(ld_a), .tp(tp_a), .run(run_a), .done(done_a));

    wash_seq_ctrl #(.TICK_DIV(3), .T_FILL(TF), .T_WASH(TW), .T_DRAIN(TD),
                    .T_RINSE(TR), .T_SPIN(TS)) u_div3 (
        .ts(ts), .p(p), .mod(mod), .mod1(mod1), .s(s),
        .Tt(tt_b), .Tm(tm_b), .li(li_b), .lw(lw_b), .lo(lo_b), .lr(lr_b),
        .ld(ld_b), .tp(tp_b), .run(run_b), .done(done_b));

    always #5 ts = ~ts;

    logic [21:0] obs_a, obs_b;
    assign obs_a = {tt_a, tm_a, tp_a, li_a, lw_a, lo_a, lr_a, ld_a, run_a, done_a};
    assign obs_b = {tt_b, tm_b, tp_b, li_b, lw_b, lo_b, lr_b, ld_b, run_b, done_b};

    // Program phase lists, straight from the program table.
    int pseq [5][7] = '{'{1,2,3,4,5,6,7}, '{1,2,3,0,0,0,0}, '{1,2,3,4,5,6,0},
                        '{4,5,6,7,0,0,0}, '{7,0,0,0,0,0,0}};
    int plen [5] = '{7, 3, 6, 4, 1};
    int divs [2] = '{1, 3};

    // Model state per instance. mode: 0 idle, 1 run, 2 pause, 3 done.
    int m_mode[2], m_prog[2], m_idx[2], m_rem[2], m_presc[2], m_idle_tt[2];
    bit m_sp[2];

    logic [43:0] sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit s_last = 1'b0;

    function automatic int dur(int ph);
        case (ph)
            1, 4:    return TF;
            2:       return TW;
            3, 6:    return TD;
            5:       return TR;
            7:       return TS;
            default: return 0;
        endcase
    endfunction

    function automatic int total(int pr);
        int t = 0;
        for (int k = 0; k < plen[pr]; k++) t += dur(pseq[pr][k]);
        return t;
    endfunction

    task automatic model_step(int i, bit pp, bit mm, int m1, bit ss);
        bit e;
        if (!pp) begin
            m_mode[i] = 0; m_prog[i] = 0; m_idx[i] = 0; m_rem[i] = 0;
            m_presc[i] = 0; m_idle_tt[i] = 0; m_sp[i] = 1'b0;
        end else begin
            e = ss && !m_sp[i];
            m_sp[i] = ss;
            if ((m_mode[i] == 0 || m_mode[i] == 3) && mm && m1 <= 4) begin
                m_prog[i] = m1;
                m_idle_tt[i] = total(m1);
                m_mode[i] = 0;
            end else if (e) begin
                case (m_mode[i])
                    0: if (m_idle_tt[i] != 0) begin
                        m_idx[i] = 0;
                        m_rem[i] = dur(pseq[m_prog[i]][0]);
                        m_presc[i] = 0;
                        m_mode[i] = 1;
                    end
                    1: m_mode[i] = 2;
                    2: m_mode[i] = 1;
                    default: begin
                        m_mode[i] = 0;
                        m_idle_tt[i] = total(m_prog[i]);
                    end
                endcase
            end else if (m_mode[i] == 1) begin
                m_presc[i]++;
                if (m_presc[i] == divs[i]) begin
                    m_presc[i] = 0;
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        m_idx[i]++;
                        if (m_idx[i] == plen[m_prog[i]]) m_mode[i] = 3;
                        else m_rem[i] = dur(pseq[m_prog[i]][m_idx[i]]);
                    end
                end
            end
        end
    endtask

    function automatic logic [21:0] model_obs(int i);
        int tt = 0, tm = 0, tp = 0;
        logic [4:0] lights = 5'b0;
        logic r, d;
        if (m_mode[i] == 0) begin
            tt = m_idle_tt[i];
        end else if (m_mode[i] == 3) begin
            tp = 8;
        end else begin
            tm = m_rem[i];
            tt = tm;
            for (int k = m_idx[i] + 1; k < plen[m_prog[i]]; k++) tt += dur(pseq[m_prog[i]][k]);
            tp = pseq[m_prog[i]][m_idx[i]];
            if (m_mode[i] == 1) begin
                case (tp)
                    1, 4:    lights = 5'b10000;
                    2:       lights = 5'b01000;
                    3, 6:    lights = 5'b00100;
                    5:       lights = 5'b00010;
                    default: lights = 5'b00001;
                endcase
            end
        end
        r = (m_mode[i] == 1);
        d = (m_mode[i] == 3);
        return {6'(tt), 5'(tm), 4'(tp), lights, r, d};
    endfunction

    task automatic chk(input logic [21:0] got, input logic [21:0] exp, input string nm);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got={Tt,Tm,tp,lights,run,done}=%h required=%h", nm, cyc, got, exp);
        end
    endtask

    // Monitor: compare every post-edge output snapshot with the scoreboard.
    initial begin
        logic [43:0] e;
        forever begin
            @(posedge ts);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(obs_a, e[43:22], "div1");
                chk(obs_b, e[21:0], "div3");
            end
        end
    end

    task automatic cycle(bit pp, bit mm, int m1, bit ss);
        @(negedge ts);
        p = pp; mod = mm; mod1 = 3'(m1); s = ss;
        cyc++;
        model_step(0, pp, mm, m1, ss);
        model_step(1, pp, mm, m1, ss);
        sb.push_back({model_obs(0), model_obs(1)});
        if (pp && (mm || (ss && !s_last)))
            $display("txn cyc=%0d mod=%0b mod1=%0d s_edge=%0b -> tp=%0d/%0d Tt=%0d/%0d",
                     cyc, mm, m1, ss && !s_last, model_obs(0)[10:7], model_obs(1)[10:7],
                     model_obs(0)[21:16], model_obs(1)[21:16]);
        s_last = pp ? ss : 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) cycle(1, 0, 0, 0);
    endtask

    task automatic press();
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 0);
    endtask

    task automatic power_off_check();
        @(posedge ts);
        #3;
        p = 1'b0;
        #1;
        chk(obs_a, 22'd0, "poweroff_async_div1");
        chk(obs_b, 22'd0, "poweroff_async_div3");
    endtask

    initial begin
        bit ss, mm;
        int m1;
        for (int i = 0; i < 2; i++) model_step(i, 1'b0, 1'b0, 0, 1'b0);
        // Reset, then a start with nothing loaded.
        repeat (3) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        press();
        idle(3);
        // Program 0, with an ignored load mid-run.
        cycle(1, 1, 0, 0);
        press();
        idle(12);
        cycle(1, 1, 4, 0);
        idle(20);
        // Load together with a start edge in DONE: load wins.
        cycle(1, 1, 4, 1);
        cycle(1, 0, 0, 0);
        // Out-of-range program select ignored.
        cycle(1, 1, 6, 0);
        idle(1);
        // Program 4 to completion, then DONE -> IDLE reload.
        press();
        idle(16);
        press();
        idle(2);
        // Program 1 with a long pause.
        cycle(1, 1, 1, 0);
        press();
        idle(3);
        press();
        idle(20);
        press();
        idle(30);
        // Program 3, power lost during RINSE on the TICK_DIV=3 instance.
        cycle(1, 1, 3, 0);
        press();
        idle(8);
        power_off_check();
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        press();
        idle(3);
        // Randomized traffic.
        ss = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            mm = ($urandom_range(0, 19) == 0);
            m1 = $urandom_range(0, 7);
            if ($urandom_range(0, 5) == 0) ss = ~ss;
            if (mm && m1 >= 5 && ss && !s_last) ss = 1'b0;
            if ($urandom_range(0, 399) == 0) begin
                cycle(0, 0, 0, 0);
                ss = 1'b0;
            end else begin
                cycle(1, mm, m1, ss);
            end
        end
        idle(2);
        @(negedge ts);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
